usb_stream_frame_bridge: RTL and testbench

//  Parses the USB-CDC host byte stream (bulk OUT) into framed word writes for fabric config.

---
 rtl/usb_stream_frame_bridge.sv | 206 ++++++++++++++++++++
 tb/tb_usb_stream_frame_bridge.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_stream_frame_bridge.sv
// Turns the host bulk OUT byte stream into framed, CMD-tagged word writes.
// Each completed frame is answered with an ACK byte, and each rejected command with a NAK byte, on the bulk IN port.
module usb_stream_frame_bridge #(
    parameter int          DATA_WIDTH     = 32,
    parameter logic [7:0]  SYNC0          = 8'hAA,
    parameter logic [7:0]  SYNC1          = 8'hFF,
    parameter int          NUM_CMDS       = 2,
    parameter int          ACK_EN         = 1,
    parameter int          TIMEOUT_CYCLES = 0
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic [7:0]            out_data_i,
    input  logic                  out_valid_i,
    output logic                  out_ready_o,
    output logic [7:0]            in_data_o,
    output logic                  in_valid_o,
    input  logic                  in_ready_i,
    output logic [DATA_WIDTH-1:0] word_data_o,
    output logic [7:0]            word_cmd_o,
    output logic                  word_last_o,
    output logic                  word_valid_o,
    input  logic                  word_ready_i,
    output logic                  frame_err_o,
    output logic                  usb_led_o,
    output logic [2:0]            dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // A valid side holds its payload stable until that transfer.

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int TCW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [BCW-1:0] BYTE_LAST = BCW'(BYTES - 1);
    localparam logic [TCW-1:0] IDLE_LIM  = TCW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_HUNT0 = 3'd0,
        S_HUNT1 = 3'd1,
        S_CMD   = 3'd2,
        S_LEN   = 3'd3,
        S_DATA  = 3'd4,
        S_ACK   = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_alive;
    logic [7:0]            r_cmd;
    logic [8:0]            r_words_left;
    logic [BCW-1:0]        r_byte_cnt;
    logic [TCW-1:0]        r_idle;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_word_data;
    logic [7:0]            r_word_cmd;
    logic                  r_word_last;
    logic                  r_word_valid;
    logic [7:0]            r_in_data;
    logic                  r_in_valid;
    logic                  r_frame_err;
    logic                  r_led;

    logic                  w_accept;
    logic                  w_timed;
    logic                  w_cmd_ok;
    logic                  w_word_hs;
    logic                  w_status_hs;
    logic                  w_timeout;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic                  w_latch_cmd;
    logic                  w_bad_cmd;
    logic                  w_latch_len;
    logic                  w_shift;
    logic                  w_word_done;
    logic                  w_send_ack;
    logic                  w_send_nak;

    // r_alive keeps out_ready_o low during reset and for the first cycle after it.
    assign out_ready_o  = r_alive && !r_word_valid && !r_in_valid;
    assign w_accept     = out_valid_i && out_ready_o;
    assign w_timed      = (r_state == S_CMD) || (r_state == S_LEN) || (r_state == S_DATA);
    assign w_cmd_ok     = (out_data_i != 8'd0) && (out_data_i <= 8'(NUM_CMDS));
    assign w_word_hs    = r_word_valid && word_ready_i;
    assign w_status_hs  = r_in_valid && in_ready_i;
    assign w_timeout    = (TIMEOUT_CYCLES > 0) && w_timed && !w_accept && !r_word_valid
                          && (r_idle == IDLE_LIM);
    assign w_shift_next = DATA_WIDTH'({r_shift, out_data_i});

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) r_state <= S_HUNT0;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_HUNT0: if (w_accept && out_data_i == SYNC0) w_next = S_HUNT1;
            S_HUNT1: begin
                if (w_accept) begin
                    if (out_data_i == SYNC1)      w_next = S_CMD;
                    else if (out_data_i != SYNC0) w_next = S_HUNT0;
                end
            end
            S_CMD: begin
                if (w_timeout)     w_next = S_HUNT0;
                else if (w_accept) w_next = w_cmd_ok ? S_LEN : S_HUNT0;
            end
            S_LEN: begin
                if (w_timeout)     w_next = S_HUNT0;
                else if (w_accept) w_next = S_DATA;
            end
            S_DATA: begin
                if (w_timeout)                      w_next = S_HUNT0;
                else if (w_word_hs && r_word_last)  w_next = (ACK_EN != 0) ? S_ACK : S_HUNT0;
            end
            S_ACK:   if (w_status_hs) w_next = S_HUNT0;
            default: w_next = S_HUNT0;
        endcase
    end

    always_comb begin
        w_latch_cmd = (r_state == S_CMD) && w_accept && w_cmd_ok;
        w_bad_cmd   = (r_state == S_CMD) && w_accept && !w_cmd_ok;
        w_latch_len = (r_state == S_LEN) && w_accept;
        w_shift     = (r_state == S_DATA) && w_accept;
        w_word_done = w_shift && (r_byte_cnt == BYTE_LAST);
        w_send_ack  = (r_state == S_DATA) && w_word_hs && r_word_last && (ACK_EN != 0);
        w_send_nak  = w_bad_cmd && (ACK_EN != 0);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_alive      <= 1'b0;
            r_cmd        <= 8'h00;
            r_words_left <= 9'd0;
            r_byte_cnt   <= '0;
            r_idle       <= '0;
            r_shift      <= '0;
            r_word_data  <= '0;
            r_word_cmd   <= 8'h00;
            r_word_last  <= 1'b0;
            r_word_valid <= 1'b0;
            r_in_data    <= 8'h00;
            r_in_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_led        <= 1'b0;
        end else begin
            r_alive     <= 1'b1;
            r_frame_err <= w_bad_cmd || w_timeout;

            if (!w_timed || w_accept || r_word_valid) r_idle <= '0;
            else                                       r_idle <= r_idle + 1'b1;

            if (w_latch_cmd) begin
                r_cmd <= out_data_i;
                r_led <= 1'b1;
            end

            // A LEN byte of zero selects the full 256-word frame.
            if (w_latch_len) begin
                r_words_left <= (out_data_i == 8'd0) ? 9'd256 : {1'b0, out_data_i};
                r_byte_cnt   <= '0;
            end

            if (w_shift) begin
                r_shift <= w_shift_next;
                if (w_word_done) begin
                    r_word_data  <= w_shift_next;
                    r_word_cmd   <= r_cmd;
                    r_word_last  <= (r_words_left == 9'd1);
                    r_word_valid <= 1'b1;
                    r_words_left <= r_words_left - 9'd1;
                    r_byte_cnt   <= '0;
                end else begin
                    r_byte_cnt   <= r_byte_cnt + 1'b1;
                end
            end else if (w_word_hs) begin
                r_word_valid <= 1'b0;
            end

            if (w_timeout) r_byte_cnt <= '0;

            if (w_send_ack) begin
                r_in_data  <= 8'h06;
                r_in_valid <= 1'b1;
            end else if (w_send_nak) begin
                r_in_data  <= 8'h15;
                r_in_valid <= 1'b1;
            end else if (w_status_hs) begin
                r_in_valid <= 1'b0;
            end
        end
    end

    assign in_data_o    = r_in_data;
    assign in_valid_o   = r_in_valid;
    assign word_data_o  = r_word_data;
    assign word_cmd_o   = r_word_cmd;
    assign word_last_o  = r_word_last;
    assign word_valid_o = r_word_valid;
    assign frame_err_o  = r_frame_err;
    assign usb_led_o    = r_led;
    assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_usb_stream_frame_bridge.sv
// Bench for usb_stream_frame_bridge: directed frames plus a random byte stream,
// scored against a frame parser that works on the whole stream at once.
module tb_usb_stream_frame_bridge;

    localparam int DW = 32;
    localparam int NB = DW / 8;
    localparam int TO = 16;

    logic          clk_i = 1'b0;
    logic          reset_n_i = 1'b0;
    logic [7:0]    out_data_i = 8'h00;
    logic          out_valid_i = 1'b0;
    logic          out_ready_o;
    logic [7:0]    in_data_o;
    logic          in_valid_o;
    logic          in_ready_i = 1'b0;
    logic [DW-1:0] word_data_o;
    logic [7:0]    word_cmd_o;
    logic          word_last_o;
    logic          word_valid_o;
    logic          word_ready_i = 1'b0;
    logic          frame_err_o;
    logic          usb_led_o;
    logic [2:0]    dbg_state_o;

    always #5 clk_i = ~clk_i;

    usb_stream_frame_bridge #(
        .DATA_WIDTH(DW), .SYNC0(8'hAA), .SYNC1(8'hFF),
        .NUM_CMDS(2), .ACK_EN(1), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .out_data_i(out_data_i), .out_valid_i(out_valid_i), .out_ready_o(out_ready_o),
        .in_data_o(in_data_o), .in_valid_o(in_valid_o), .in_ready_i(in_ready_i),
        .word_data_o(word_data_o), .word_cmd_o(word_cmd_o), .word_last_o(word_last_o),
        .word_valid_o(word_valid_o), .word_ready_i(word_ready_i),
        .frame_err_o(frame_err_o), .usb_led_o(usb_led_o), .dbg_state_o(dbg_state_o)
    );

    int            n_tests = 0;
    int            n_fail = 0;
    logic [DW+8:0] exp_q[$];      // {last, cmd, data}
    logic [7:0]    exp_st_q[$];
    logic [7:0]    stream_q[$];
    int            exp_err = 0;
    int            err_seen = 0;
    logic          exp_led = 1'b0;
    int            sink_mode = 1;  // 0 random, 1 always ready, 2 word sink stalled
    int            max_gap = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk_i);
        #1;
        case (sink_mode)
            0: begin
                word_ready_i = ($urandom_range(0, 3) != 0);
                in_ready_i   = ($urandom_range(0, 1) != 0);
            end
            1: begin
                word_ready_i = 1'b1;
                in_ready_i   = 1'b1;
            end
            default: begin
                word_ready_i = 1'b0;
                in_ready_i   = 1'b1;
            end
        endcase
    end

    // Scoreboard: handshakes are judged at the negedge, between input updates and the next edge.
    initial forever begin
        @(negedge clk_i);
        if (reset_n_i) begin
            if (word_valid_o) check_eq("ready_while_word", out_ready_o, 0);
            if (word_valid_o && word_ready_i) begin
                if (exp_q.size() == 0) check_eq("word_unexpected", exp_q.size(), 1);
                else check_eq("word", {word_last_o, word_cmd_o, word_data_o}, exp_q.pop_front());
            end
            if (in_valid_o && in_ready_i) begin
                if (exp_st_q.size() == 0) check_eq("status_unexpected", exp_st_q.size(), 1);
                else check_eq("status", in_data_o, exp_st_q.pop_front());
            end
            if (frame_err_o) err_seen++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Whole-stream frame parser: finds SYNC0 SYNC1, then CMD, LEN and LEN big-endian words.
    task automatic model_stream();
        int n, i, j, k, len;
        logic [7:0]    cmd;
        logic [DW-1:0] word;
        logic          complete;
        n = stream_q.size();
        i = 0;
        while (i < n) begin
            if (stream_q[i] != 8'hAA) begin
                i++;
                continue;
            end
            j = i + 1;
            while (j < n && stream_q[j] == 8'hAA) j++;
            if (j >= n) break;
            if (stream_q[j] != 8'hFF) begin
                i = j + 1;
                continue;
            end
            if (j + 1 >= n) break;
            cmd = stream_q[j+1];
            if (cmd < 8'd1 || cmd > 8'd2) begin
                exp_err++;
                exp_st_q.push_back(8'h15);
                i = j + 2;
                continue;
            end
            exp_led = 1'b1;
            if (j + 2 >= n) break;
            len = (stream_q[j+2] == 8'd0) ? 256 : int'(stream_q[j+2]);
            k = j + 3;
            complete = 1'b1;
            for (int w = 0; w < len; w++) begin
                if (k + NB > n) begin
                    complete = 1'b0;
                    break;
                end
                word = '0;
                for (int b = 0; b < NB; b++) word = (word << 8) | DW'(stream_q[k+b]);
                exp_q.push_back({(w == len - 1), cmd, word});
                k += NB;
            end
            if (!complete) break;
            exp_st_q.push_back(8'h06);
            i = k;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int gap;
        int cyc;
        gap = $urandom_range(0, max_gap);
        repeat (gap) begin
            @(posedge clk_i);
            #1;
        end
        out_data_i  = b;
        out_valid_i = 1'b1;
        cyc = 0;
        forever begin
            @(negedge clk_i);
            if (out_ready_o) break;
            cyc++;
            if (cyc > 2000) begin
                check_eq("byte_accept_timeout", cyc, 0);
                break;
            end
        end
        @(posedge clk_i);
        #1;
        out_valid_i = 1'b0;
    endtask

    task automatic send_stream();
        foreach (stream_q[i]) send_byte(stream_q[i]);
    endtask

    task automatic drain_and_check(input string tag);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || exp_st_q.size() != 0) && cyc < 5000) begin
            @(posedge clk_i);
            cyc++;
        end
        check_eq({tag, "_drain"}, exp_q.size() + exp_st_q.size(), 0);
        repeat (4) @(posedge clk_i);
        #1;
        check_eq({tag, "_frame_err"}, err_seen, exp_err);
        check_eq({tag, "_led"}, usb_led_o, exp_led);
        check_eq({tag, "_idle_word"}, word_valid_o, 0);
    endtask

    task automatic do_reset();
        reset_n_i   = 1'b0;
        out_valid_i = 1'b0;
        out_data_i  = 8'h00;
        exp_q.delete();
        exp_st_q.delete();
        stream_q.delete();
        exp_err  = 0;
        err_seen = 0;
        exp_led  = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("rst_out_ready", out_ready_o, 0);
        check_eq("rst_in_valid", in_valid_o, 0);
        check_eq("rst_in_data", in_data_o, 8'h00);
        check_eq("rst_word_valid", word_valid_o, 0);
        check_eq("rst_word_data", word_data_o, 0);
        check_eq("rst_word_cmd", word_cmd_o, 0);
        check_eq("rst_word_last", word_last_o, 0);
        check_eq("rst_frame_err", frame_err_o, 0);
        check_eq("rst_led", usb_led_o, 0);
        reset_n_i = 1'b1;
        repeat (2) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic push_bytes(input logic [7:0] b[$]);
        foreach (b[i]) stream_q.push_back(b[i]);
    endtask

    function automatic logic [7:0] payload_byte();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return 8'hAA;
        if (r == 1) return 8'hFF;
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic add_segment();
        int t, len, nj;
        t = $urandom_range(0, 9);
        if (t <= 5 || t == 7) begin
            stream_q.push_back(8'hAA);
            if (t == 7) repeat ($urandom_range(1, 2)) stream_q.push_back(8'hAA);
            stream_q.push_back(8'hFF);
            stream_q.push_back(8'($urandom_range(1, 2)));
            len = $urandom_range(1, 4);
            stream_q.push_back(8'(len));
            repeat (len * NB) stream_q.push_back(payload_byte());
        end else if (t == 6) begin
            push_bytes('{8'hAA, 8'hFF});
            stream_q.push_back(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(3, 255)));
        end else if (t == 8) begin
            nj = $urandom_range(1, 3);
            repeat (nj) stream_q.push_back(8'($urandom_range(0, 8'hA9)));
        end else begin
            stream_q.push_back(8'hAA);
            stream_q.push_back(8'($urandom_range(0, 8'hA9)));
        end
    endtask

    initial begin
        int cyc;

        // Single word frame, ACK afterwards, word visible the cycle after its last byte.
        do_reset();
        sink_mode = 1;
        max_gap = 0;
        push_bytes('{8'hAA, 8'hFF, 8'h01, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF});
        model_stream();
        send_stream();
        check_eq("word_latency", word_valid_o, 1);
        check_eq("word_latency_data", word_data_o, 32'hDEADBEEF);
        drain_and_check("basic");

        // Two words with the word sink stalled.
        stream_q.delete();
        sink_mode = 2;
        push_bytes('{8'hAA, 8'hFF, 8'h02, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                     8'h55, 8'h66, 8'h77, 8'h88});
        model_stream();
        fork
            send_stream();
            begin
                cyc = 0;
                while (!word_valid_o && cyc < 200) begin
                    @(negedge clk_i);
                    cyc++;
                end
                check_eq("stall_word_seen", word_valid_o, 1);
                repeat (5) begin
                    @(negedge clk_i);
                    check_eq("stall_out_ready", out_ready_o, 0);
                    check_eq("stall_hold_data", word_data_o, 32'h11223344);
                end
                sink_mode = 1;
            end
        join
        drain_and_check("stall");

        // Resync on a repeated SYNC0.
        stream_q.delete();
        push_bytes('{8'hAA, 8'hAA, 8'hFF, 8'h01, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D});
        model_stream();
        send_stream();
        drain_and_check("resync");

        // Illegal command right after reset: error pulse, NAK, LED stays dark.
        do_reset();
        push_bytes('{8'hAA, 8'hFF, 8'h07});
        model_stream();
        send_stream();
        drain_and_check("bad_cmd");

        // Timeout mid-DATA, then a clean frame.
        do_reset();
        push_bytes('{8'hAA, 8'hFF, 8'h01, 8'h01, 8'h11, 8'h22});
        send_stream();
        repeat (12) @(negedge clk_i);
        check_eq("timeout_not_early", err_seen, 0);
        cyc = 0;
        while (err_seen == 0 && cyc < 24) begin
            @(negedge clk_i);
            cyc++;
        end
        check_eq("timeout_err", err_seen, 1);
        @(posedge clk_i);
        #1;
        exp_err = 1;
        exp_led = 1'b1;
        stream_q.delete();
        push_bytes('{8'hAA, 8'hFF, 8'h02, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04});
        model_stream();
        send_stream();
        drain_and_check("timeout_recover");

        // Asynchronous reset in the middle of DATA.
        do_reset();
        push_bytes('{8'hAA, 8'hFF, 8'h01, 8'h01, 8'h12, 8'h34});
        model_stream();
        send_stream();
        check_eq("mid_led_set", usb_led_o, exp_led);
        #2;
        reset_n_i = 1'b0;
        #1;
        check_eq("async_rst_led", usb_led_o, 0);
        check_eq("async_rst_out_ready", out_ready_o, 0);
        check_eq("async_rst_state", dbg_state_o, 0);
        do_reset();
        push_bytes('{8'hAA, 8'hFF, 8'h02, 8'h01, 8'h55, 8'h66, 8'h77, 8'h88});
        model_stream();
        send_stream();
        drain_and_check("after_reset");

        // LEN of zero carries 256 words.
        stream_q.delete();
        sink_mode = 0;
        max_gap = 1;
        push_bytes('{8'hAA, 8'hFF, 8'h02, 8'h00});
        repeat (256 * NB) stream_q.push_back(payload_byte());
        model_stream();
        send_stream();
        drain_and_check("len256");

        // Random mix of frames, bad commands, resyncs and junk.
        do_reset();
        sink_mode = 0;
        max_gap = 3;
        repeat (40) add_segment();
        model_stream();
        send_stream();
        drain_and_check("random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
